// File: rtl/sync_fifo_lvl.sv
// Single-clock level-tracking FIFO buffer between datapath stages.
// Latency: 1 cycle rd_en to rd_data (registered mode); flags/level 1 cycle after access.
// Backpressure: writes rejected while full, reads rejected while empty; each rejection pulses an error flag.
//
// sync_fifo_lvl
//   Depth D may be any value 2..1024 (not only powers of two); pointers wrap
//   from D-1 to 0 by explicit compare. Level and all status flags are
//   registered and decoded from the next-state level.
//
//   Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through, where
//   rd_data shows the head of queue combinationally, rd_valid = ~empty and
//   rd_en acknowledges/pops the displayed word. Undefined (default) gives
//   registered read data with rd_valid marking the cycle after a pop.
//
// Ports
//   clk           in   1   rising-edge clock
//   reset_n       in   1   asynchronous reset, active low
//   wr_en         in   1   write request
//   wr_data       in   W   write data
//   rd_en         in   1   read request (pop)
//   rd_data       out  W   read data
//   rd_valid      out  1   rd_data holds a popped / head word
//   full          out  1   level == D
//   empty         out  1   level == 0
//   almost_full   out  1   level >= AF_LVL
//   almost_empty  out  1   level <= AE_LVL
//   level         out  LW  words currently stored
//   overflow      out  1   one-cycle pulse after a rejected write
//   underflow     out  1   one-cycle pulse after a rejected read

module sync_fifo_lvl #(
   parameter  int W      = 8,
   parameter  int D      = 16,
   parameter  int AF_LVL = D - 2,
   parameter  int AE_LVL = 1,
   localparam int AW     = (D > 1) ? $clog2(D) : 1,
   localparam int LW     = $clog2(D + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          rd_valid,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic [LW-1:0] level,
   output logic          overflow,
   output logic          underflow
);

   // Thresholds pre-sized to the level width so every compare is LW bits.
   localparam logic [LW-1:0] DEPTH_L  = LW'(D);
   localparam logic [LW-1:0] AF_L     = LW'(AF_LVL);
   localparam logic [LW-1:0] AE_L     = LW'(AE_LVL);
   localparam logic [AW-1:0] PTR_LAST = AW'(D - 1);

   // Storage: intentionally not reset.
   logic [W-1:0]  mem [D];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level_q;
   logic          full_q;
   logic          empty_q;
   logic          af_q;
   logic          ae_q;
   logic          ovf_q;
   logic          unf_q;

   logic          wr_acc;
   logic          rd_acc;
   logic [LW-1:0] level_next;

   // Non-power-of-two depths need an explicit wrap rather than a rollover.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Acceptance uses the registered flags of the current cycle. At full a
   // read still drains, so a simultaneous write is rejected; at empty the
   // read is rejected and the write goes through.
   always_comb begin
      wr_acc     = wr_en & ~full_q;
      rd_acc     = rd_en & ~empty_q;
      level_next = level_q + LW'(wr_acc) - LW'(rd_acc);
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (rd_acc) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         level_q <= level_next;
         full_q  <= (level_next == DEPTH_L);
         empty_q <= (level_next == '0);
         af_q    <= (level_next >= AF_L);
         ae_q    <= (level_next <= AE_L);
         ovf_q   <= wr_en & full_q;
         unf_q   <= rd_en & empty_q;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head of queue is always on display; a word written into an empty FIFO
   // becomes visible the cycle after the write, when empty_q falls.
   always_comb begin
      rd_data  = mem[rd_ptr];
      rd_valid = ~empty_q;
   end
`else
   logic [W-1:0] rd_data_q;
   logic         rd_valid_q;

   // rd_data keeps its last popped word between reads; rd_valid only marks
   // the cycle right after an accepted read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) begin
            rd_data_q <= mem[rd_ptr];
         end
      end
   end

   always_comb begin
      rd_data  = rd_data_q;
      rd_valid = rd_valid_q;
   end
`endif

   always_comb begin
      level        = level_q;
      full         = full_q;
      empty        = empty_q;
      almost_full  = af_q;
      almost_empty = ae_q;
      overflow     = ovf_q;
      underflow    = unf_q;
   end

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Bench for sync_fifo_lvl (W=8, D=5, AF_LVL=4, AE_LVL=1): directed steps
// plus a random phase, all checked against a queue-based reference model.
// Inputs change on the falling edge; outputs are sampled 1 ns after rising.

module tb_sync_fifo_lvl;
   localparam int W  = 8;
   localparam int D  = 5;
   localparam int AF = 4;
   localparam int AE = 1;
   localparam int LW = $clog2(D + 1);

   logic          clk;
   logic          reset_n;
   logic          wr_en;
   logic [W-1:0]  wr_data;
   logic          rd_en;
   logic [W-1:0]  rd_data;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [LW-1:0] level;
   logic          overflow;
   logic          underflow;

   sync_fifo_lvl #(.W(W), .D(D), .AF_LVL(AF), .AE_LVL(AE)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .level        (level),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: contents as a plain queue plus expected pulse outputs.
   logic [W-1:0] q[$];
   logic         e_ovf;
   logic         e_unf;
   logic         e_vld;
   logic [W-1:0] e_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string ctx);
      int n;
      n = q.size();
      chk({ctx, ":level"},        32'(level),        32'(n));
      chk({ctx, ":full"},         32'(full),         32'(n == D));
      chk({ctx, ":empty"},        32'(empty),        32'(n == 0));
      chk({ctx, ":almost_full"},  32'(almost_full),  32'(n >= AF));
      chk({ctx, ":almost_empty"}, 32'(almost_empty), 32'(n <= AE));
      chk({ctx, ":overflow"},     32'(overflow),     32'(e_ovf));
      chk({ctx, ":underflow"},    32'(underflow),    32'(e_unf));
`ifdef SYNC_FIFO_FWFT_EN
      chk({ctx, ":rd_valid"},     32'(rd_valid),     32'(n != 0));
      if (n != 0) chk({ctx, ":rd_data"}, 32'(rd_data), 32'(q[0]));
`else
      chk({ctx, ":rd_valid"},     32'(rd_valid),     32'(e_vld));
      chk({ctx, ":rd_data"},      32'(rd_data),      32'(e_data));
`endif
   endtask

   // One clock of stimulus; model decides acceptance from pre-edge occupancy.
   task automatic step(input string ctx, input logic w, input logic [W-1:0] d, input logic r);
      int  n;
      bit  wa;
      bit  ra;
      @(negedge clk);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      n  = q.size();
      wa = w && (n < D);
      ra = r && (n > 0);
      @(posedge clk);
      #1;
      e_ovf = w && !wa;
      e_unf = r && !ra;
      e_vld = ra;
      if (ra) e_data = q.pop_front();
      if (wa) q.push_back(d);
      check_all(ctx);
   endtask

   task automatic model_reset();
      q.delete();
      e_ovf  = 1'b0;
      e_unf  = 1'b0;
      e_vld  = 1'b0;
      e_data = '0;
   endtask

   initial begin
      logic [W-1:0] v;
      reset_n = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      rd_en   = 1'b0;
      model_reset();

      // 1: reset state
      #12;
      check_all("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // 2: fill 0x11..0x15, then one write too many
      for (int i = 0; i < D; i++) step("fill", 1'b1, 8'h11 + 8'(i), 1'b0);
      step("fill_ovf", 1'b1, 8'h16, 1'b0);
      step("fill_idle", 1'b0, 8'h00, 1'b0);

      // 3: drain in order, then one read too many
      for (int i = 0; i < D; i++) step("drain", 1'b0, 8'h00, 1'b1);
      step("drain_unf", 1'b0, 8'h00, 1'b1);
      step("drain_idle", 1'b0, 8'h00, 1'b0);

      // 4: steady level 2 across the pointer wrap
      step("wrap_pre", 1'b1, 8'h21, 1'b0);
      step("wrap_pre", 1'b1, 8'h22, 1'b0);
      for (int i = 0; i < 12; i++) step("wrap_rw", 1'b1, 8'($urandom), 1'b1);
      step("wrap_idle", 1'b0, 8'h00, 1'b0);

      // 5: collisions at full and at empty
      while (q.size() < D) step("coll_fill", 1'b1, 8'($urandom), 1'b0);
      step("coll_full", 1'b1, 8'h5a, 1'b1);
      while (q.size() > 0) step("coll_drain", 1'b0, 8'h00, 1'b1);
      step("coll_empty", 1'b1, 8'ha5, 1'b1);
      step("coll_idle", 1'b0, 8'h00, 1'b0);

      // 6: asynchronous reset mid-operation at level 3
      while (q.size() < 3) step("mrst_fill", 1'b1, 8'($urandom), 1'b0);
      step("mrst_idle", 1'b0, 8'h00, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all("mrst_async");
      #1;
      reset_n = 1'b1;
      step("mrst_read", 1'b0, 8'h00, 1'b1);

      // Random traffic, biased alternately toward filling and draining.
      for (int i = 0; i < 400; i++) begin
         bit wb;
         bit rb;
         wb = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         rb = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         v  = 8'($urandom);
         step("rand", wb, v, rb);
      end
      step("final_idle", 1'b0, 8'h00, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
